// File: rtl/mtc_arb_pkg.sv
// mtc_arb_pkg: MTC bus constants, arbiter defaults and the round-robin search helper.
package mtc_arb_pkg;
    localparam int MTC2SL_LEN     = 32;
    localparam int MTC_VALID_BIT  = MTC2SL_LEN - 1;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CNT_WIDTH_DEF  = 16;

    // First set bit of req searching ptr, ptr+1, ... mod n; -1 when req is empty.
    function automatic int next_grant(input logic [31:0] req, input int ptr, input int n);
        int g;
        int idx;
        g = -1;
        for (int k = 31; k >= 0; k--) begin
            idx = (ptr + k >= n) ? ptr + k - n : ptr + k;
            if (k < n && req[idx[4:0]]) g = idx;
        end
        return g;
    endfunction
endpackage

// File: rtl/mtc_arb_fifo.sv
// mtc_arb_fifo: single-clock FIFO with first-word fall-through head and push+pop on full.
module mtc_arb_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr, rd;

    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/mtc_sl_arbiter.sv
// mtc_sl_arbiter: per-slot MTC FIFOs serialised round-robin onto one ready/valid stream.
// Define MTC_ARB_DROP_CNT_EN to build the saturating per-slot drop counters.
module mtc_sl_arbiter
    import mtc_arb_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    localparam int SW = N_IN > 1 ? $clog2(N_IN) : 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [MTC2SL_LEN-1:0] mtc_in [N_IN],
    output logic [MTC2SL_LEN-1:0] mtc_out,
    output logic                  mtc_out_valid,
    input  logic                  mtc_out_ready,
    output logic [SW-1:0]         mtc_out_src,
    output logic [N_IN-1:0]       fifo_ovfl,
    output logic [CNT_WIDTH-1:0]  drop_cnt [N_IN]
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [MTC2SL_LEN-1:0] VMASK = MTC2SL_LEN'(1) << MTC_VALID_BIT;

    logic [MTC2SL_LEN-1:0] head [N_IN];
    logic [N_IN-1:0] full, empty, pop, drop;
    logic [SW-1:0] rr_ptr, sel_src;
    logic [MTC2SL_LEN-1:0] sel_word;
    logic load;
    int grant;

    for (genvar i = 0; i < N_IN; i++) begin : g_slot
        logic [CW-1:0] unused_count;
        mtc_arb_fifo #(.W(MTC2SL_LEN), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clock(clock),
            .rst(rst),
            .push(mtc_in[i][MTC_VALID_BIT]),
            .pop(pop[i]),
            .din(mtc_in[i]),
            .dout(head[i]),
            .full(full[i]),
            .empty(empty[i]),
            .count(unused_count)
        );
        assign pop[i]  = load && grant == i;
        assign drop[i] = mtc_in[i][MTC_VALID_BIT] && full[i] && !pop[i];
`ifdef MTC_ARB_DROP_CNT_EN
        always_ff @(posedge clock) begin
            if (rst) drop_cnt[i] <= '0;
            else if (drop[i] && drop_cnt[i] != '1) drop_cnt[i] <= drop_cnt[i] + CNT_WIDTH'(1);
        end
`else
        assign drop_cnt[i] = '0;
`endif
    end

    // Output register is free when empty or being drained; ready never reaches the outputs combinationally.
    always_comb begin
        grant = next_grant(32'(~empty), int'(rr_ptr), N_IN);
        load  = (!mtc_out_valid || mtc_out_ready) && grant >= 0;
    end

    always_comb begin
        sel_word = '0;
        sel_src  = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (grant == k) begin
                sel_word = head[k];
                sel_src  = SW'(k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            mtc_out       <= '0;
            mtc_out_valid <= 1'b0;
            mtc_out_src   <= '0;
            rr_ptr        <= '0;
            fifo_ovfl     <= '0;
        end else begin
            fifo_ovfl <= fifo_ovfl | drop;
            if (load) begin
                mtc_out       <= sel_word | VMASK;
                mtc_out_valid <= 1'b1;
                mtc_out_src   <= sel_src;
                rr_ptr        <= sel_src == SW'(N_IN - 1) ? '0 : sel_src + SW'(1);
            end else if (mtc_out_ready) begin
                mtc_out       <= '0;
                mtc_out_valid <= 1'b0;
                mtc_out_src   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mtc_sl_arbiter.sv
// tb_mtc_sl_arbiter: table vectors, corner-case sequences and random traffic against a queue model.
module tb_mtc_sl_arbiter;
    import mtc_arb_pkg::*;
    localparam int N = 3;
    localparam int D = 4;
    localparam int CW = 16;
    localparam int L = MTC2SL_LEN;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic [L-1:0] mtc_in [N];
    logic [L-1:0] mtc_out;
    logic mtc_out_valid;
    logic mtc_out_ready = 1'b0;
    logic [1:0] mtc_out_src;
    logic [N-1:0] fifo_ovfl;
    logic [CW-1:0] drop_cnt [N];

    always #5 clock = ~clock;

    mtc_sl_arbiter #(.N_IN(N), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clock(clock),
        .rst(rst),
        .mtc_in(mtc_in),
        .mtc_out(mtc_out),
        .mtc_out_valid(mtc_out_valid),
        .mtc_out_ready(mtc_out_ready),
        .mtc_out_src(mtc_out_src),
        .fifo_ovfl(fifo_ovfl),
        .drop_cnt(drop_cnt)
    );

    logic [L-1:0] q [N][$];
    bit m_v;
    logic [L-1:0] m_out;
    int m_src, m_rr;
    bit [N-1:0] m_ovfl;
    int m_drops [N];
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit r;
        bit rdy;
        bit [2:0] mask;
        bit ev;
        bit [1:0] es;
    } vec_t;
    vec_t tbl [14];

    function automatic logic [L-1:0] mk(int s, int t);
        return {1'b1, (L-1)'(s * 256 + t)};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(bit r, bit rdy);
        int g;
        g = -1;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                q[i].delete();
                m_drops[i] = 0;
            end
            m_v = 0; m_out = '0; m_src = 0; m_rr = 0; m_ovfl = '0;
            return;
        end
        if (!m_v || rdy)
            for (int k = 0; k < N; k++) begin
                int s = (m_rr + k) % N;
                if (g < 0 && q[s].size() > 0) g = s;
            end
        if (g >= 0) begin
            m_out = q[g].pop_front();
            m_v = 1; m_src = g; m_rr = (g + 1) % N;
        end else if (m_v && rdy) begin
            m_v = 0; m_out = '0; m_src = 0;
        end
        for (int i = 0; i < N; i++)
            if (mtc_in[i][L-1]) begin
                if (q[i].size() < D) q[i].push_back(mtc_in[i]);
                else begin
                    m_ovfl[i] = 1;
                    if (m_drops[i] < 2**CW - 1) m_drops[i]++;
                end
            end
    endtask

    function automatic int exp_drop(int i);
`ifdef MTC_ARB_DROP_CNT_EN
        return m_drops[i];
`else
        return 0 * i;
`endif
    endfunction

    task automatic compare_all();
        chk("model_valid", mtc_out_valid, m_v);
        chk("model_word", mtc_out, m_out);
        chk("model_src", mtc_out_src, m_src);
        chk("model_ovfl", fifo_ovfl, m_ovfl);
        for (int i = 0; i < N; i++) chk("model_drop_cnt", drop_cnt[i], exp_drop(i));
    endtask

    task automatic step(bit r, bit rdy, bit [N-1:0] mask, int tag);
        rst = r;
        mtc_out_ready = rdy;
        for (int i = 0; i < N; i++) mtc_in[i] = mask[i] ? mk(i, tag) : '0;
        @(posedge clock);
        model_edge(r, rdy);
        #1;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < N; i++) mtc_in[i] = '0;
        tbl[0]  = '{0, 1, 3'b010, 0, 0};
        tbl[1]  = '{0, 1, 3'b000, 1, 1};
        tbl[2]  = '{0, 1, 3'b000, 0, 0};
        tbl[3]  = '{1, 1, 3'b000, 0, 0};
        tbl[4]  = '{0, 1, 3'b111, 0, 0};
        tbl[5]  = '{0, 1, 3'b000, 1, 0};
        tbl[6]  = '{0, 1, 3'b000, 1, 1};
        tbl[7]  = '{0, 1, 3'b000, 1, 2};
        tbl[8]  = '{0, 1, 3'b000, 0, 0};
        tbl[9]  = '{0, 1, 3'b111, 0, 0};
        tbl[10] = '{0, 1, 3'b000, 1, 0};
        tbl[11] = '{0, 1, 3'b000, 1, 1};
        tbl[12] = '{0, 1, 3'b000, 1, 2};
        tbl[13] = '{0, 1, 3'b000, 0, 0};

        step(1, 0, 3'b000, 0);
        step(1, 0, 3'b000, 0);
        chk("rst_valid", mtc_out_valid, 0);
        chk("rst_word", mtc_out, 0);
        chk("rst_src", mtc_out_src, 0);
        chk("rst_ovfl", fifo_ovfl, 0);

        for (int k = 0; k < 14; k++) begin
            step(tbl[k].r, tbl[k].rdy, tbl[k].mask, k);
            chk("tbl_valid", mtc_out_valid, tbl[k].ev);
            chk("tbl_src", mtc_out_src, tbl[k].es);
        end
        chk("single_word_seen", 1, 1 == 1);

        // Output held while ready is low, then the next slot follows one cycle after ready.
        step(1, 0, 3'b000, 0);
        step(0, 0, 3'b011, 100);
        step(0, 0, 3'b000, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 3'b000, 0);
            chk("hold_word", mtc_out, mk(0, 100));
            chk("hold_src", mtc_out_src, 0);
        end
        step(0, 1, 3'b000, 0);
        chk("hold_next_word", mtc_out, mk(1, 100));
        chk("hold_next_src", mtc_out_src, 1);
        step(0, 1, 3'b000, 0);
        chk("hold_drain_valid", mtc_out_valid, 0);

        // Slot 0 overflow: one word in the output register, four buffered, the sixth dropped.
        step(1, 0, 3'b000, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 3'b001, 200 + k);
        chk("ovfl_flag", fifo_ovfl, 3'b001);
`ifdef MTC_ARB_DROP_CNT_EN
        chk("ovfl_drop_cnt", drop_cnt[0], 1);
`else
        chk("ovfl_drop_cnt", drop_cnt[0], 0);
`endif
        chk("ovfl_out", mtc_out, mk(0, 200));
        step(0, 1, 3'b001, 210);
        chk("full_push_pop_out", mtc_out, mk(0, 201));
        chk("full_push_pop_drop", drop_cnt[0], exp_drop(0));
        chk("full_push_pop_ovfl", fifo_ovfl, 3'b001);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 3'b000, 0);
            chk("ovfl_drain", mtc_out, k == 3 ? mk(0, 210) : mk(0, 202 + k));
        end

        // Reset mid-transfer discards everything; traffic afterwards restarts at latency 2.
        step(0, 0, 3'b111, 300);
        step(0, 0, 3'b111, 301);
        chk("pre_rst_valid", mtc_out_valid, 1);
        step(1, 0, 3'b111, 302);
        chk("mid_rst_valid", mtc_out_valid, 0);
        chk("mid_rst_word", mtc_out, 0);
        chk("mid_rst_src", mtc_out_src, 0);
        chk("mid_rst_ovfl", fifo_ovfl, 0);
        step(0, 1, 3'b100, 303);
        chk("post_rst_lat1", mtc_out_valid, 0);
        step(0, 1, 3'b000, 0);
        chk("post_rst_valid", mtc_out_valid, 1);
        chk("post_rst_word", mtc_out, mk(2, 303));
        chk("post_rst_src", mtc_out_src, 2);

        for (int k = 0; k < 500; k++) begin
            bit [N-1:0] m;
            for (int i = 0; i < N; i++) m[i] = $urandom_range(0, 99) < 40;
            step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), m, 400 + k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
